instruction_fetch_unit: RTL and testbench

Fetch stage directly upstream of the single-cycle control unit. Holds the program counter, fetches each instruction from instruction memory over a req/ack handshake, and latches it into an instruction register. Slices out `Opcode`, `Funct3`, `Funct7` and the register indices for the control unit and register file. Computes the next PC from the control unit's `PCSrc` and the datapath's branch and jump targets.

---
 rtl/rv_fetch_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: next-PC select codes,
// fetch FSM states and reset constants.
package rv_fetch_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StExec  = 2'b01,
        StHalt  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux with word-alignment check of the selected target.
module next_pc_sel
    import rv_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            PCSRC_BRANCH: next_pc = branch_target;
            // jalr clears bit 0 of the computed target
            PCSRC_JALR:   next_pc = {jalr_target[XLEN-1:1], 1'b0};
            default:      next_pc = pc_plus4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, req/ack instruction fetch into the instruction
// register, field slicing and next-PC update with sticky misalignment fault.
module instruction_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_plus4,
    output logic [31:0]     Instr,
    output logic [6:0]      Opcode,
    output logic [4:0]      rd,
    output logic [2:0]      Funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      Funct7,
    output logic            instr_valid,
    output logic            fetch_misaligned,
    output logic [31:0]     instret
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     instret_q, instret_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    assign pc_plus4 = pc_q + XLEN'(4);

    next_pc_sel #(
        .XLEN (XLEN)
    ) u_next_pc_sel (
        .PCSrc         (PCSrc),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        fault_d   = fault_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                // stall takes priority over a misaligned target
                if (!stall) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = StFetch;
                    end
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    // Gated by rst so a pending request vanishes the moment reset asserts
    assign imem_req         = rst && (state_q == StFetch);
    assign imem_addr        = pc_q;
    assign instr_valid      = (state_q == StExec);
    assign fetch_misaligned = fault_q;
    assign instret          = instret_q;

    assign PC       = pc_q;
    assign PC_plus4 = pc_plus4;
    assign Instr    = instr_q;
    assign Opcode   = instr_q[6:0];
    assign rd       = instr_q[11:7];
    assign Funct3   = instr_q[14:12];
    assign rs1      = instr_q[19:15];
    assign rs2      = instr_q[24:20];
    assign Funct7   = instr_q[31:25];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed and randomized
// fetch/exec sequences checked against a PC/instret reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] branch_target = '0;
    logic [31:0] jalr_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] PC, PC_plus4, Instr, instret;
    logic [6:0]  Opcode, Funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  Funct3;
    logic        instr_valid, fetch_misaligned;

    instruction_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .PCSrc            (PCSrc),
        .branch_target    (branch_target),
        .jalr_target      (jalr_target),
        .stall            (stall),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ack         (imem_ack),
        .PC               (PC),
        .PC_plus4         (PC_plus4),
        .Instr            (Instr),
        .Opcode           (Opcode),
        .rd               (rd),
        .Funct3           (Funct3),
        .rs1              (rs1),
        .rs2              (rs2),
        .Funct7           (Funct7),
        .instr_valid      (instr_valid),
        .fetch_misaligned (fetch_misaligned),
        .instret          (instret)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_instr;
    logic        m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_exec(input logic [31:0] w);
        logic [31:0] t;
        chk("exec_valid", {31'b0, instr_valid}, 32'd1);
        chk("exec_req", {31'b0, imem_req}, 32'd0);
        chk("exec_instr", Instr, w);
        chk("exec_pc", PC, m_pc);
        chk("exec_pc4", PC_plus4, m_pc + 32'd4);
        chk("exec_instret", instret, m_instret);
        t = w;
        chk("fields", {Funct7, rs2, rs1, Funct3, rd, Opcode}, t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b0;
        stall = 1'b0;
        #1;
        chk("rst_pc", PC, RST_PC);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_opcode", {25'b0, Opcode}, 32'h13);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_fault", {31'b0, fetch_misaligned}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_pc = RST_PC;
        m_instret = 0;
        m_instr = 32'h0000_0013;
        m_fault = 1'b0;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, RST_PC);
    endtask

    // One instruction: FETCH with 'waits' wait cycles, EXEC with 'stalls' stall cycles.
    // Called at a negedge with the DUT in FETCH; returns at a negedge.
    task automatic do_instr(input int waits, input int stalls, input logic [1:0] src,
                            input logic [31:0] bt, input logic [31:0] jt,
                            input logic [31:0] w);
        logic [31:0] nxt;
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            PCSrc = 2'($urandom);
            #1;
            chk("wait_req", {31'b0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_valid", {31'b0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        imem_ack = 1'b1;
        imem_rdata = w;
        #1;
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        @(negedge clk);
        m_instr = w;
        for (int i = 0; i < stalls; i++) begin
            imem_ack = 1'($urandom);
            imem_rdata = $urandom;
            stall = 1'b1;
            PCSrc = 2'b01;
            branch_target = m_pc + 32'd2;
            jalr_target = $urandom;
            #1;
            chk_exec(w);
            @(negedge clk);
        end
        stall = 1'b0;
        imem_ack = 1'($urandom);
        imem_rdata = $urandom;
        PCSrc = src;
        branch_target = bt;
        jalr_target = jt;
        #1;
        chk_exec(w);
        case (src)
            2'b01:   nxt = bt;
            2'b10:   nxt = jt - (jt % 2);
            default: nxt = m_pc + 32'd4;
        endcase
        if (nxt % 4 != 0) begin
            m_fault = 1'b1;
        end else begin
            m_pc = nxt;
            m_instret = m_instret + 1;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        PCSrc = 2'b00;
        #1;
        chk("post_fault", {31'b0, fetch_misaligned}, {31'b0, m_fault});
        chk("post_pc", PC, m_pc);
        chk("post_instret", instret, m_instret);
        chk("post_req", {31'b0, imem_req}, {31'b0, !m_fault});
        chk("post_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] bt, jt;
        logic [1:0]  src;

        // Reset and release
        do_reset();

        // Sequential zero-wait fetches
        do_instr(0, 0, 2'b00, '0, '0, 32'h0000_0013);
        chk("seq_pc1", PC, 32'h0040_0004);
        do_instr(0, 0, 2'b00, '0, '0, 32'h00A3_0333);
        chk("add_fields", {Opcode, 3'b0, rd, 3'b0, rs1, 3'b0, rs2},
            {7'h33, 3'b0, 5'd6, 3'b0, 5'd6, 3'b0, 5'd10});
        do_instr(0, 0, 2'b00, '0, '0, 32'h0010_0093);
        chk("seq_instret3", instret, 32'd3);
        chk("seq_pc3", PC, 32'h0040_000C);

        // Wait states and stall
        do_instr(3, 2, 2'b00, '0, '0, 32'h0020_8113);

        // Branch, jalr (bit 0 cleared), reserved select
        do_instr(0, 0, 2'b01, 32'h0040_0100, '0, 32'h0000_0063);
        chk("branch_addr", imem_addr, 32'h0040_0100);
        do_instr(1, 0, 2'b10, '0, 32'h0040_0201, 32'h0000_0067);
        chk("jalr_addr", imem_addr, 32'h0040_0200);
        do_instr(0, 1, 2'b11, 32'h0000_1000, 32'h0000_2000, 32'h0000_0013);
        chk("rsvd_addr", imem_addr, 32'h0040_0204);

        // PC+4 wrap
        do_instr(0, 0, 2'b01, 32'hFFFF_FFFC, '0, 32'h0000_0063);
        do_instr(0, 0, 2'b00, '0, '0, 32'h0000_0013);
        chk("wrap_pc", PC, 32'h0000_0000);

        // Randomized aligned traffic
        for (int n = 0; n < 40; n++) begin
            src = 2'($urandom);
            bt = $urandom;
            bt = bt - (bt % 4);
            jt = $urandom;
            jt = jt - (jt % 4) + (jt % 2);
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), src, bt, jt,
                     $urandom);
        end

        // Reset mid-fetch
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_pc", PC, RST_PC);
        chk("midrst_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_pc = RST_PC;
        m_instret = 0;
        m_fault = 1'b0;
        #1;
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, RST_PC);
        @(negedge clk);

        // Misaligned fault (first cycle stalled with bad target: no fault yet)
        do_instr(0, 1, 2'b01, 32'h0040_0102, '0, 32'h0000_0063);
        chk("fault_flag", {31'b0, fetch_misaligned}, 32'd1);
        chk("fault_pc", PC, 32'h0040_0000);
        chk("fault_instret", instret, 32'd0);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1;
            imem_rdata = $urandom;
            PCSrc = 2'($urandom);
            branch_target = $urandom;
            stall = 1'($urandom);
            @(negedge clk);
            #1;
            chk("halt_req", {31'b0, imem_req}, 32'd0);
            chk("halt_valid", {31'b0, instr_valid}, 32'd0);
            chk("halt_fault", {31'b0, fetch_misaligned}, 32'd1);
            chk("halt_pc", PC, m_pc);
            chk("halt_instr", Instr, m_instr);
            chk("halt_instret", instret, m_instret);
        end

        // Reset leaves HALT
        do_reset();
        do_instr(0, 0, 2'b00, '0, '0, 32'h0000_0013);
        chk("after_halt_pc", PC, 32'h0040_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
